// File: rtl/priority_encoder_rr.sv
// Registered N-line priority encoder with a fixed-priority or round-robin winner,
// a single output register, and a valid/ready handshake on both sides.
module priority_encoder_rr #(
    parameter  int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         mode,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] idx,
    output logic [N-1:0] onehot,
    output logic         none
);

    logic [W-1:0] last;
    logic [W-1:0] rr_start;
    logic [W-1:0] sel;
    logic [N-1:0] sel_onehot;
    logic         accept;
    logic         req_any;

    // Index k steps below base, wrapped into 0..N-1 so non-power-of-two N stays in range.
    function automatic logic [W-1:0] wrap_down(input logic [W-1:0] base, input int k);
        int v;
        v = (int'(base) + N - k) % N;
        return W'(v);
    endfunction

    assign req_ready = !out_valid || out_ready;
    assign accept    = req_valid && req_ready;
    assign req_any   = |req;
    assign rr_start  = (last == '0) ? W'(N - 1) : last - 1'b1;

    // NOTE: sel is defaulted before the loops so every path assigns it and no latch is inferred.
    always_comb begin
        sel = '0;
        if (!mode) begin
            for (int i = 0; i < N; i++) begin
                if (req[i]) sel = W'(i);
            end
        end else begin
            // Walk from the farthest position back to rr_start; the last hit is the first in search order.
            for (int k = N - 1; k >= 0; k--) begin
                if (req[wrap_down(rr_start, k)]) sel = wrap_down(rr_start, k);
            end
        end
    end

    assign sel_onehot = req_any ? (N'(1) << sel) : '0;

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            idx       <= '0;
            onehot    <= '0;
            none      <= 1'b0;
            last      <= '0;
        end else if (accept) begin
            out_valid <= 1'b1;
            idx       <= req_any ? sel : '0;
            onehot    <= sel_onehot;
            none      <= !req_any;
            if (mode && req_any) last <= sel;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
